// File: rtl/dioptase_mmio_pkg.sv
// Shared MMIO map and DMA definitions for the VRAM copy engine.
//   SRC/DST/LEN/CTRL register byte addresses, memory read latency,
//   transfer length width and the DMA state enum.
package dioptase_mmio_pkg;

  localparam logic [17:0] SRC_ADDR  = 18'h20010;
  localparam logic [17:0] DST_ADDR  = 18'h20014;
  localparam logic [17:0] LEN_ADDR  = 18'h20018;
  localparam logic [17:0] CTRL_ADDR = 18'h2001C;

  localparam int unsigned READ_LATENCY = 2;
  localparam int unsigned LEN_W        = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } dma_state_t;

endpackage

// File: rtl/vram_dma_regs.sv
// MMIO decode and register file for the VRAM DMA.
//   clk, rst, clk_en : clock, sync active-high reset, memory clock enable
//   idle             : engine idle; register writes are ignored otherwise
//   wen0, waddr,
//   wdata            : CPU write request (byte-lane 0 enable, address, low data bits)
//   set_done         : engine finished a transfer this clk_en cycle
//   src, dst, len    : programmed word-aligned source/destination and word count
//   start            : qualified start (CTRL bit0 written with nonzero LEN)
//   done             : sticky completion flag
module vram_dma_regs
  import dioptase_mmio_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             idle,
  input  logic             wen0,
  input  logic [17:0]      waddr,
  input  logic [17:0]      wdata,
  input  logic             set_done,
  output logic [17:0]      src,
  output logic [17:0]      dst,
  output logic [LEN_W-1:0] len,
  output logic             start,
  output logic             done
);

  logic wr_en;
  logic ctrl_wr;

  assign wr_en   = idle && wen0;
  assign ctrl_wr = wr_en && (waddr == CTRL_ADDR);
  assign start   = clk_en && ctrl_wr && wdata[0] && (len != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      src  <= '0;
      dst  <= '0;
      len  <= '0;
      done <= 1'b0;
    end else if (clk_en) begin
      if (wr_en) begin
        case (waddr)
          SRC_ADDR: src <= {wdata[17:2], 2'b00};
          DST_ADDR: dst <= {wdata[17:2], 2'b00};
          LEN_ADDR: len <= wdata[LEN_W-1:0];
          default:  ;
        endcase
      end
      // set_done only occurs while busy and ctrl_wr only while idle, so they
      // never collide; a clear+start write clears now and sets at completion.
      if (set_done) begin
        done <= 1'b1;
      end else if (ctrl_wr && wdata[1]) begin
        done <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vram_dma.sv
// VRAM DMA: sits between the CPU data port and memory, forwards CPU traffic
// while idle and copies LEN words from SRC to DST when started.
//   clk, rst, clk_en        : clock, sync active-high reset, memory clock enable
//   cpu_raddr1/wen/waddr/wdata : CPU data-port request
//   cpu_rdata1, cpu_stall   : read data / status to CPU, CPU freeze
//   mem_raddr1/wen/waddr/wdata : memory read port 1 and write port
//   mem_rdata1              : memory read port 1 data
//   irq                     : one clk_en-cycle transfer-complete pulse
module vram_dma
  import dioptase_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [17:0] cpu_raddr1,
  input  logic [3:0]  cpu_wen,
  input  logic [17:0] cpu_waddr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata1,
  output logic        cpu_stall,
  output logic [17:0] mem_raddr1,
  output logic [3:0]  mem_wen,
  output logic [17:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata1,
  output logic        irq
);

  dma_state_t       state;
  dma_state_t       state_next;
  logic [17:0]      cur_src;
  logic [17:0]      cur_dst;
  logic [LEN_W-1:0] remaining;
  logic [17:0]      raddr_pipe [READ_LATENCY];

  logic             idle;
  logic             busy;
  logic             set_done;
  logic             start;
  logic             done;
  logic [17:0]      reg_src;
  logic [17:0]      reg_dst;
  logic [LEN_W-1:0] reg_len;

  assign idle = (state == ST_IDLE);
  assign busy = !idle;

  vram_dma_regs u_regs (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .idle     (idle),
    .wen0     (cpu_wen[0]),
    .waddr    (cpu_waddr),
    .wdata    (cpu_wdata[17:0]),
    .set_done (set_done),
    .src      (reg_src),
    .dst      (reg_dst),
    .len      (reg_len),
    .start    (start),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        raddr_pipe[i] <= '0;
      end
    end else if (clk_en) begin
      state <= state_next;
      if (idle && start) begin
        cur_src   <= reg_src;
        cur_dst   <= reg_dst;
        remaining <= reg_len;
      end
      if (state == ST_WRITE) begin
        cur_src   <= cur_src + 18'd4;
        cur_dst   <= cur_dst + 18'd4;
        remaining <= remaining - LEN_W'(1);
      end
      raddr_pipe[0] <= cpu_raddr1;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        raddr_pipe[i] <= raddr_pipe[i-1];
      end
    end
  end

  always_comb begin
    state_next = state;
    mem_raddr1 = cpu_raddr1;
    mem_waddr  = cpu_waddr;
    mem_wdata  = cpu_wdata;
    mem_wen    = idle ? cpu_wen : '0;
    irq        = 1'b0;
    set_done   = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_next = ST_START;
      ST_START: state_next = ST_ISSUE;
      ST_ISSUE: begin
        mem_raddr1 = cur_src;
        state_next = ST_WAIT;
      end
      ST_WAIT:  state_next = ST_WRITE;
      ST_WRITE: begin
        mem_waddr  = cur_dst;
        mem_wdata  = mem_rdata1;
        mem_wen    = '1;
        state_next = (remaining > LEN_W'(1)) ? ST_ISSUE : ST_DONE;
      end
      ST_DONE: begin
        irq        = 1'b1;
        set_done   = 1'b1;
        state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  assign cpu_stall  = busy;
  assign cpu_rdata1 = (raddr_pipe[READ_LATENCY-1] == CTRL_ADDR) ? {30'b0, done, busy}
                                                                : mem_rdata1;

endmodule
